rr_multichan_recorder: RTL

RR_MULTICHAN_RECORDER -- requirements
Module: rr_multichan_recorder

---
 rtl/rr_rec_pkg.sv | 23 ++
 rtl/rr_sync_fifo.sv | 56 +++++
 rtl/rr_multichan_recorder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rr_rec_pkg.sv
// rtl/rr_rec_pkg.sv - shared types and widths for the multichannel recorder (optional RR_REC_TIMESTAMP_EN)
package rr_rec_pkg;

    localparam int TS_W = 16;

`ifdef RR_REC_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } rec_state_t;

    // Entry layout, MSB first: [timestamp], busy, fire, payload.
    function automatic int log_w(input int nch, input int ch_width);
        return 2 * nch + nch * ch_width + (TS_EN ? TS_W : 0);
    endfunction

endpackage

// File: rtl/rr_sync_fifo.sv
// rtl/rr_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module rr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     sync_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/rr_multichan_recorder.sv
// rtl/rr_multichan_recorder.sv - pass-through valid/ready recorder logging every handshake cycle (optional RR_REC_TIMESTAMP_EN)
module rr_multichan_recorder
    import rr_rec_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int CH_WIDTH = 64,
    parameter int DEPTH    = 16,
    localparam int LOG_W   = log_w(NCH, CH_WIDTH)
) (
    input  logic                    clk,
    input  logic                    sync_rst,
    input  logic [NCH-1:0]          ch_in_valid,
    output logic [NCH-1:0]          ch_in_ready,
    input  logic [NCH*CH_WIDTH-1:0] ch_data,
    output logic [NCH-1:0]          ch_out_valid,
    input  logic [NCH-1:0]          ch_out_ready,
    output logic                    log_valid,
    input  logic                    log_ready,
    output logic [LOG_W-1:0]        log_data,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic [31:0]             stall_cycles
);

    localparam int CW = $clog2(DEPTH) + 1;

    rec_state_t              state;
    logic                    stall;
    logic                    gate;
    logic [NCH-1:0]          fire;
    logic [NCH-1:0]          busy;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [CW-1:0]           count;
    logic [CW-1:0]           occ_next;
    logic [NCH*CH_WIDTH-1:0] payload;
    logic [LOG_W-1:0]        entry;

    // fifo_full can never assert (stall caps occupancy at DEPTH-1); it only backs up the stall.
    assign gate         = stall | fifo_full | sync_rst | (state != ST_RUN);
    assign ch_out_valid = ch_in_valid & {NCH{~gate}};
    assign ch_in_ready  = ch_out_ready & {NCH{~gate}};
    assign fire         = ch_in_valid & ch_in_ready;
    assign busy         = ch_in_valid & ~ch_in_ready;
    assign push         = |fire;
    assign log_valid    = ~fifo_empty & ~sync_rst;
    assign pop          = log_valid & log_ready;
    assign occ_next     = count + CW'(push) - CW'(pop);
    assign flush_done   = (state == ST_DONE);

    always_comb begin
        payload = '0;
        for (int i = 0; i < NCH; i++) begin
            if (fire[i]) begin
                payload[i*CH_WIDTH +: CH_WIDTH] = ch_data[i*CH_WIDTH +: CH_WIDTH];
            end
        end
    end

`ifdef RR_REC_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            ts_cnt <= '0;
        end else if (push) begin
            ts_cnt <= TS_W'(1);
        end else if (ts_cnt != '1) begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    assign entry = {ts_cnt, busy, fire, payload};
`else
    assign entry = {busy, fire, payload};
`endif

    // Stall looks at the post-update occupancy so log_ready never reaches ch_in_ready combinationally.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            stall <= 1'b0;
        end else begin
            stall <= (occ_next >= CW'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   state <= flush_req ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state <= fifo_empty ? ST_DONE : ST_FLUSH;
                ST_DONE:  state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            stall_cycles <= '0;
        end else if (gate && (|ch_in_valid) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    rr_sync_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (DEPTH)
    ) u_log_fifo (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .push      (push),
        .push_data (entry),
        .pop       (pop),
        .head_data (log_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (count)
    );

endmodule
